// File: rtl/mesh_pkg.sv
// Shared constants for the mesh NIC: packet width, VC bit position and register map.
package mesh_pkg;

    localparam int DATA_WIDTH   = 64;
    localparam int VC_BIT       = DATA_WIDTH - 1;
    localparam int STAT_CNT_LSB = 16;

    localparam logic [1:0] NIC_IN_DATA  = 2'b00;
    localparam logic [1:0] NIC_IN_STAT  = 2'b01;
    localparam logic [1:0] NIC_OUT_DATA = 2'b10;
    localparam logic [1:0] NIC_OUT_STAT = 2'b11;

endpackage

// File: rtl/nic_chan_buf.sv
// Single-entry packet buffer with a full flag; a write is only taken while empty.
module nic_chan_buf #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] data,
    output logic             full
);

    // A fill while empty wins over a drain; data is kept after draining so stale reads see it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data <= '0;
            full <= 1'b0;
        end else if (wr && !full) begin
            data <= wr_data;
            full <= 1'b1;
        end else if (rd) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/mesh_nic.sv
// PE-side network interface for one mesh router: register map, polarity gating, read mux.
// Define NIC_STATS_EN to build saturating tx/rx counters reported in the status registers.
module mesh_nic #(
    parameter int DATA_WIDTH = mesh_pkg::DATA_WIDTH
`ifdef NIC_STATS_EN
    , parameter int CNT_WIDTH = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_polarity,
    output logic                  net_so,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_ro,
    input  logic                  net_si,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_ri
);
    import mesh_pkg::*;

    logic                  rd_strobe;
    logic                  out_wr;
    logic                  in_rd;
    logic                  in_wr;
    logic                  out_full;
    logic                  in_full;
    logic [DATA_WIDTH-1:0] out_buf;
    logic [DATA_WIDTH-1:0] in_buf;
    logic [DATA_WIDTH-1:0] in_stat;
    logic [DATA_WIDTH-1:0] out_stat;

    assign rd_strobe = nicEn & ~nicWrEn;
    assign out_wr    = nicEn & nicWrEn & (addr == NIC_OUT_DATA);
    assign in_rd     = rd_strobe & (addr == NIC_IN_DATA);
    assign in_wr     = net_si & net_ri;

    // A packet may only leave on the cycle whose router polarity matches its VC bit.
    assign net_so = out_full & net_ro & (out_buf[DATA_WIDTH-1] == net_polarity);
    assign net_do = out_full ? out_buf : '0;
    assign net_ri = ~in_full;

    nic_chan_buf #(.WIDTH(DATA_WIDTH)) u_out_buf (
        .clk     (clk),
        .reset   (reset),
        .wr      (out_wr),
        .rd      (net_so),
        .wr_data (d_in),
        .data    (out_buf),
        .full    (out_full)
    );

    nic_chan_buf #(.WIDTH(DATA_WIDTH)) u_in_buf (
        .clk     (clk),
        .reset   (reset),
        .wr      (in_wr),
        .rd      (in_rd),
        .wr_data (net_di),
        .data    (in_buf),
        .full    (in_full)
    );

`ifdef NIC_STATS_EN
    logic [CNT_WIDTH-1:0] tx_cnt;
    logic [CNT_WIDTH-1:0] rx_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_cnt <= '0;
            rx_cnt <= '0;
        end else begin
            if (net_so && (tx_cnt != '1))
                tx_cnt <= tx_cnt + CNT_WIDTH'(1);
            if (in_wr && (rx_cnt != '1))
                rx_cnt <= rx_cnt + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        in_stat  = '0;
        out_stat = '0;
        in_stat[0]  = in_full;
        out_stat[0] = out_full;
        in_stat[STAT_CNT_LSB +: CNT_WIDTH]  = rx_cnt;
        out_stat[STAT_CNT_LSB +: CNT_WIDTH] = tx_cnt;
    end
`else
    always_comb begin
        in_stat  = '0;
        out_stat = '0;
        in_stat[0]  = in_full;
        out_stat[0] = out_full;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out <= '0;
        end else if (rd_strobe) begin
            case (addr)
                NIC_IN_DATA:  d_out <= in_buf;
                NIC_IN_STAT:  d_out <= in_stat;
                NIC_OUT_DATA: d_out <= '0;
                default:      d_out <= out_stat;
            endcase
        end
    end

endmodule

// File: tb/tb_mesh_nic.sv
// Randomized and directed bench for mesh_nic against a transaction-level model of the NIC.
module tb_mesh_nic;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  addr = 2'b00;
    logic [63:0] d_in = '0;
    logic [63:0] d_out;
    logic        nicEn = 1'b0;
    logic        nicWrEn = 1'b0;
    logic        net_polarity = 1'b0;
    logic        net_so;
    logic [63:0] net_do;
    logic        net_ro = 1'b0;
    logic        net_si = 1'b0;
    logic [63:0] net_di = '0;
    logic        net_ri;

    int total = 0;
    int bad   = 0;

    logic        m_out_full;
    logic        m_in_full;
    logic [63:0] m_out_val;
    logic [63:0] m_in_val;
    logic [63:0] m_dout;
    int unsigned m_tx;
    int unsigned m_rx;

    mesh_nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_polarity (net_polarity),
        .net_so       (net_so),
        .net_do       (net_do),
        .net_ro       (net_ro),
        .net_si       (net_si),
        .net_di       (net_di),
        .net_ri       (net_ri)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] status_word(input logic full, input int unsigned cnt);
        logic [63:0] w;
        w = 64'(full);
`ifdef NIC_STATS_EN
        w = w | (64'(cnt) << 16);
`else
        if (cnt > 32'hFFFF_FFFE) w = w;
`endif
        return w;
    endfunction

    task automatic model_reset();
        m_out_full = 1'b0;
        m_in_full  = 1'b0;
        m_out_val  = '0;
        m_in_val   = '0;
        m_dout     = '0;
        m_tx       = 0;
        m_rx       = 0;
    endtask

    // One processor/network cycle: drive at negedge, check outputs, advance model at posedge.
    task automatic applyStimulus(input logic en, input logic we, input logic [1:0] a,
                                 input logic [63:0] din, input logic ro, input logic si,
                                 input logic [63:0] di);
        logic inject;
        logic accept;
        @(negedge clk);
        nicEn        = en;
        nicWrEn      = we;
        addr         = a;
        d_in         = din;
        net_ro       = ro;
        net_si       = si;
        net_di       = di;
        net_polarity = ~net_polarity;
        #1;
        inject = m_out_full && ro && (m_out_val[63] == net_polarity);
        accept = si && !m_in_full;
        checkOutput("net_so", 64'(net_so), 64'(inject));
        checkOutput("net_do", net_do, m_out_full ? m_out_val : 64'h0);
        checkOutput("net_ri", 64'(net_ri), 64'(!m_in_full));
        @(posedge clk);
        if (en && !we) begin
            case (a)
                2'b00:   m_dout = m_in_val;
                2'b01:   m_dout = status_word(m_in_full, m_rx);
                2'b10:   m_dout = 64'h0;
                default: m_dout = status_word(m_out_full, m_tx);
            endcase
        end
        if (accept) begin
            m_in_val  = di;
            m_in_full = 1'b1;
            if (m_rx < 65535) m_rx++;
        end else if (en && !we && a == 2'b00) begin
            m_in_full = 1'b0;
        end
        if (inject) begin
            m_out_full = 1'b0;
            if (m_tx < 65535) m_tx++;
        end else if (en && we && a == 2'b10 && !m_out_full) begin
            m_out_val  = din;
            m_out_full = 1'b1;
        end
        #1;
        checkOutput("d_out", d_out, m_dout);
    endtask

    task automatic idle(input logic ro, input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 2'b00, 64'h0, ro, 0, 64'h0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_so", 64'(net_so), 64'h0);
        checkOutput("rst_ri", 64'(net_ri), 64'h1);
        checkOutput("rst_dout", d_out, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1, 0, 2'b01, 64'h0, 0, 0, 64'h0);
        applyStimulus(1, 0, 2'b11, 64'h0, 0, 0, 64'h0);

        $display("[TB] inject VC=1 packet");
        applyStimulus(1, 1, 2'b10, 64'h8000_0000_0000_00AA, 1, 0, 64'h0);
        idle(1, 3);
        applyStimulus(1, 0, 2'b11, 64'h0, 1, 0, 64'h0);

        $display("[TB] full-buffer drop");
        applyStimulus(1, 1, 2'b10, 64'h1, 0, 0, 64'h0);
        applyStimulus(1, 1, 2'b10, 64'h2, 0, 0, 64'h0);
        applyStimulus(1, 0, 2'b11, 64'h0, 0, 0, 64'h0);
        idle(1, 4);
        applyStimulus(1, 0, 2'b11, 64'h0, 1, 0, 64'h0);

        $display("[TB] eject and backpressure");
        applyStimulus(0, 0, 2'b00, 64'h0, 0, 1, 64'hDEAD_BEEF);
        applyStimulus(0, 0, 2'b00, 64'h0, 0, 1, 64'h1234_5678);
        applyStimulus(1, 0, 2'b01, 64'h0, 0, 1, 64'h1234_5678);
        applyStimulus(1, 0, 2'b00, 64'h0, 0, 1, 64'h1234_5678);
        applyStimulus(0, 0, 2'b00, 64'h0, 0, 1, 64'h1234_5678);
        applyStimulus(1, 0, 2'b01, 64'h0, 0, 0, 64'h0);
        applyStimulus(1, 0, 2'b00, 64'h0, 0, 0, 64'h0);
        applyStimulus(1, 0, 2'b10, 64'h0, 0, 0, 64'h0);
        applyStimulus(1, 1, 2'b00, 64'hFFFF, 0, 0, 64'h0);
        applyStimulus(1, 0, 2'b00, 64'h0, 0, 0, 64'h0);

        $display("[TB] random traffic");
        for (int i = 0; i < 500; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), {$urandom, $urandom},
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          {$urandom, $urandom});
        end

        $display("[TB] async reset with packet pending");
        idle(1, 4);
        applyStimulus(1, 1, 2'b10, 64'h8000_0000_0000_0055, 0, 0, 64'h0);
        @(negedge clk);
        nicEn        = 1'b0;
        net_ro       = 1'b1;
        net_polarity = 1'b1;
        #1;
        checkOutput("pre_rst_so", 64'(net_so), 64'(m_out_full && m_out_val[63]));
        #1;
        reset = 1'b0;
        #1;
        checkOutput("async_so", 64'(net_so), 64'h0);
        checkOutput("async_do", net_do, 64'h0);
        checkOutput("async_ri", 64'(net_ri), 64'h1);
        checkOutput("async_dout", d_out, 64'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1, 0, 2'b11, 64'h0, 1, 0, 64'h0);

`ifdef NIC_STATS_EN
        $display("[TB] tx counter after three injections");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 1, 2'b10, 64'(k + 1), 1, 0, 64'h0);
            idle(1, 3);
        end
        applyStimulus(1, 0, 2'b11, 64'h0, 0, 0, 64'h0);
        checkOutput("tx_cnt", 64'(d_out[31:16]), 64'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
